lpgbt_uplink_link_ctrl: RTL and testbench
=========================================

LPGBT_UPLINK_LINK_CTRL -- requirements
Module: lpgbt_uplink_link_ctrl

Interface
REQ-001 SHALL have parameters: RST_CYCLES, default 16, reset pulse length in clocks.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, max wait for each ready flag.
REQ-003 SHALL have parameter BACKOFF_CYCLES, default 256, idle time between retries.
REQ-004 SHALL have parameter FEC_WINDOW, default 1024, FEC monitor window in clocks.
REQ-005 SHALL have parameter FEC_LIMIT, default 8, FEC pulses per window that force relock.
REQ-006 One clock; reset is synchronous and active-high. Ports: clk40_i in 1, uplink 40 MHz clock; rst_i in 1, synchronous active-high reset.
REQ-007 SHALL have port enable_i in 1, software link enable (AXI register bit).
REQ-008 SHALL have port mgt_rx_rdy_i in 1, transceiver RX reset done.
REQ-009 SHALL have port uplinkrdy_i in 1, uplink frame/header lock.
REQ-010 SHALL have port uplinkFEC_i in 1, one-clock pulse per FEC-corrected frame.
REQ-011 SHALL have port cnt_clr_i in 1, one-clock pulse that clears the counters.
REQ-012 SHALL have port mgt_rst_o out 1, transceiver RX reset.
REQ-013 SHALL have port uplink_rst_o out 1, uplink datapath reset.
REQ-014 SHALL have port link_up_o out 1, high only in LINKED.
REQ-015 SHALL have port state_o out 3, FSM state encoding.
REQ-016 SHALL have port retry_cnt_o out 8, saturating count of failed attempts.
REQ-017 SHALL have port fec_cnt_o out 16, saturating total of FEC pulses while LINKED.

Function
REQ-018 States and encodings SHALL be: IDLE=0, MGT_RST=1, WAIT_MGT=2, UPL_RST=3, WAIT_LOCK=4, LINKED=5, BACKOFF=6.
REQ-019 IDLE: enable_i=1 -> MGT_RST next clock.
REQ-020 MGT_RST: mgt_rst_o=1 and uplink_rst_o=1 for exactly RST_CYCLES clocks, then WAIT_MGT.
REQ-021 WAIT_MGT: mgt_rst_o=0, uplink_rst_o=1; mgt_rx_rdy_i=1 -> UPL_RST; TIMEOUT_CYCLES clocks without it -> BACKOFF.
REQ-022 UPL_RST: uplink_rst_o=1 for exactly RST_CYCLES clocks, then WAIT_LOCK.
REQ-023 WAIT_LOCK: uplinkrdy_i=1 -> LINKED; mgt_rx_rdy_i=0 or timeout -> BACKOFF.
REQ-024 LINKED: uplinkrdy_i=0 or mgt_rx_rdy_i=0 -> BACKOFF; window FEC count reaching FEC_LIMIT -> BACKOFF on the following clock.
REQ-025 Every entry to BACKOFF SHALL increment retry_cnt_o, saturating at 255.
REQ-026 BACKOFF SHALL hold both resets high for BACKOFF_CYCLES clocks, then go to MGT_RST.
REQ-027 enable_i=0 in any state SHALL go to IDLE next clock, assert both resets, and leave counters unchanged.
REQ-028 The window counter SHALL run only in LINKED and restart on window wrap; the window FEC counter SHALL clear on wrap and on LINKED entry.
REQ-029 fec_cnt_o SHALL count uplinkFEC_i pulses only in LINKED, saturating at 65535.
REQ-030 cnt_clr_i SHALL zero retry_cnt_o and fec_cnt_o next clock; if a simultaneous increment occurs, clear wins.
REQ-031 A ready flag and timeout expiring on the same clock SHALL resolve to the ready (success) transition.
REQ-032 All outputs SHALL be registered; state_o SHALL equal the current state.

Reset
REQ-033 With rst_i=1: state IDLE, mgt_rst_o=1, uplink_rst_o=1, link_up_o=0, all counters 0; rst_i mid-sequence SHALL abort to IDLE next clock.

Structure
REQ-034 State encoding and parameter defaults SHALL live in shared package lpgbt_ctrl_pkg.
REQ-035 One sub-module, lpgbt_fec_window_mon, SHALL hold the window and FEC-limit logic and produce a one-clock relock pulse.

Verification
REQ-036 enable_i=1 with rx_rdy at clock 30 and uplinkrdy at clock 60 -> link_up_o=1, retry_cnt_o=0, mgt_rst_o high exactly 16 clocks.
REQ-037 mgt_rx_rdy_i held 0 -> BACKOFF after 4096 WAIT_MGT clocks, retry_cnt_o=1, MGT_RST re-entered after 256 clocks.
REQ-038 In LINKED, 8 FEC pulses within 1024 clocks -> BACKOFF, fec_cnt_o=8; 7 pulses per window -> stays LINKED.
REQ-039 uplinkrdy_i drop in LINKED -> link_up_o=0 next clock, retry_cnt_o increments; cnt_clr_i simultaneous -> retry_cnt_o=0.
REQ-040 300 forced failures -> retry_cnt_o=255; enable_i=0 mid-WAIT_LOCK -> IDLE, resets asserted, counters kept.

Source files
------------

// File: rtl/lpgbt_ctrl_pkg.sv
// Shared definitions for the lpGBT uplink link controller: state encoding,
// parameter defaults, per-state output decode and saturating counter helpers.
package lpgbt_ctrl_pkg;

    localparam int DEF_RST_CYCLES     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 4096;
    localparam int DEF_BACKOFF_CYCLES = 256;
    localparam int DEF_FEC_WINDOW     = 1024;
    localparam int DEF_FEC_LIMIT      = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MGT_RST   = 3'd1,
        ST_WAIT_MGT  = 3'd2,
        ST_UPL_RST   = 3'd3,
        ST_WAIT_LOCK = 3'd4,
        ST_LINKED    = 3'd5,
        ST_BACKOFF   = 3'd6
    } link_state_t;

    typedef struct packed {
        logic mgt_rst;
        logic uplink_rst;
        logic link_up;
    } link_outs_t;

    // Reset/link outputs are a pure function of the state being entered.
    function automatic link_outs_t outs_for(link_state_t s);
        link_outs_t o;
        o = '{mgt_rst: 1'b1, uplink_rst: 1'b1, link_up: 1'b0};
        case (s)
            ST_WAIT_MGT:  o = '{mgt_rst: 1'b0, uplink_rst: 1'b1, link_up: 1'b0};
            ST_UPL_RST:   o = '{mgt_rst: 1'b0, uplink_rst: 1'b1, link_up: 1'b0};
            ST_WAIT_LOCK: o = '{mgt_rst: 1'b0, uplink_rst: 1'b0, link_up: 1'b0};
            ST_LINKED:    o = '{mgt_rst: 1'b0, uplink_rst: 1'b0, link_up: 1'b1};
            default:      o = '{mgt_rst: 1'b1, uplink_rst: 1'b1, link_up: 1'b0};
        endcase
        return o;
    endfunction

    function automatic logic [7:0] sat_inc8(logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lpgbt_fec_window_mon.sv
// FEC rate monitor: counts FEC-corrected frames in fixed windows while the
// link is up and emits a one-clock relock pulse when a window hits the limit.
module lpgbt_fec_window_mon
    import lpgbt_ctrl_pkg::*;
#(
    parameter int WINDOW = DEF_FEC_WINDOW,
    parameter int LIMIT  = DEF_FEC_LIMIT
) (
    input  logic clk,
    input  logic srst,
    input  logic active,
    input  logic fec_pulse,
    output logic relock
);

    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(LIMIT);
    localparam logic [CW-1:0] CNT_EDGE  = CW'(LIMIT - 1);

    logic [WW-1:0] win_reg;
    logic [CW-1:0] cnt_reg;
    logic          relock_reg;

    // Window timer and per-window FEC count; both held clear outside LINKED so
    // every LINKED entry starts a fresh window. A pulse on the wrap clock still
    // belongs to the ending window for the limit check.
    always_ff @(posedge clk) begin
        if (srst || !active) begin
            win_reg    <= '0;
            cnt_reg    <= '0;
            relock_reg <= 1'b0;
        end else begin
            relock_reg <= fec_pulse && (cnt_reg == CNT_EDGE);
            if (win_reg == WIN_LAST) begin
                win_reg <= '0;
                cnt_reg <= '0;
            end else begin
                win_reg <= win_reg + WW'(1);
                if (fec_pulse && (cnt_reg != CNT_LIMIT)) begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end
    end

    assign relock = relock_reg;

endmodule

// File: rtl/lpgbt_uplink_link_ctrl.sv
// lpGBT uplink bring-up controller: sequences transceiver and uplink resets,
// waits for ready flags with timeouts, backs off and retries on failure, and
// forces a relock when the FEC correction rate gets too high.
module lpgbt_uplink_link_ctrl
    import lpgbt_ctrl_pkg::*;
#(
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int BACKOFF_CYCLES = DEF_BACKOFF_CYCLES,
    parameter int FEC_WINDOW     = DEF_FEC_WINDOW,
    parameter int FEC_LIMIT      = DEF_FEC_LIMIT
) (
    input  logic        clk40_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        mgt_rx_rdy_i,
    input  logic        uplinkrdy_i,
    input  logic        uplinkFEC_i,
    input  logic        cnt_clr_i,
    output logic        mgt_rst_o,
    output logic        uplink_rst_o,
    output logic        link_up_o,
    output logic [2:0]  state_o,
    output logic [7:0]  retry_cnt_o,
    output logic [15:0] fec_cnt_o
);

    localparam int TMAX_A = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int TMAX   = (TMAX_A > BACKOFF_CYCLES) ? TMAX_A : BACKOFF_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);
    localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] BO_LAST  = TW'(BACKOFF_CYCLES - 1);

    link_state_t   state_reg;
    link_outs_t    outs_reg;
    logic [TW-1:0] timer_reg;
    logic [7:0]    retry_cnt_reg;
    logic [15:0]   fec_cnt_reg;
    logic          relock;

    lpgbt_fec_window_mon #(
        .WINDOW (FEC_WINDOW),
        .LIMIT  (FEC_LIMIT)
    ) u_fec_mon (
        .clk       (clk40_i),
        .srst      (rst_i),
        .active    (state_reg == ST_LINKED),
        .fec_pulse (uplinkFEC_i),
        .relock    (relock)
    );

    // Link FSM with registered outputs; every transition restarts the state
    // timer, every BACKOFF entry counts a retry, and a counter clear wins.
    always_ff @(posedge clk40_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            outs_reg      <= outs_for(ST_IDLE);
            timer_reg     <= '0;
            retry_cnt_reg <= '0;
        end else begin
            if (!enable_i) begin
                state_reg <= ST_IDLE;
                outs_reg  <= outs_for(ST_IDLE);
                timer_reg <= '0;
            end else begin
                timer_reg <= timer_reg + TW'(1);
                case (state_reg)
                    ST_IDLE: begin
                        state_reg <= ST_MGT_RST;
                        outs_reg  <= outs_for(ST_MGT_RST);
                        timer_reg <= '0;
                    end
                    ST_MGT_RST: begin
                        if (timer_reg == RST_LAST) begin
                            state_reg <= ST_WAIT_MGT;
                            outs_reg  <= outs_for(ST_WAIT_MGT);
                            timer_reg <= '0;
                        end
                    end
                    ST_WAIT_MGT: begin
                        if (mgt_rx_rdy_i) begin
                            state_reg <= ST_UPL_RST;
                            outs_reg  <= outs_for(ST_UPL_RST);
                            timer_reg <= '0;
                        end else if (timer_reg == TO_LAST) begin
                            state_reg     <= ST_BACKOFF;
                            outs_reg      <= outs_for(ST_BACKOFF);
                            timer_reg     <= '0;
                            retry_cnt_reg <= sat_inc8(retry_cnt_reg);
                        end
                    end
                    ST_UPL_RST: begin
                        if (timer_reg == RST_LAST) begin
                            state_reg <= ST_WAIT_LOCK;
                            outs_reg  <= outs_for(ST_WAIT_LOCK);
                            timer_reg <= '0;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (uplinkrdy_i) begin
                            state_reg <= ST_LINKED;
                            outs_reg  <= outs_for(ST_LINKED);
                            timer_reg <= '0;
                        end else if (!mgt_rx_rdy_i || (timer_reg == TO_LAST)) begin
                            state_reg     <= ST_BACKOFF;
                            outs_reg      <= outs_for(ST_BACKOFF);
                            timer_reg     <= '0;
                            retry_cnt_reg <= sat_inc8(retry_cnt_reg);
                        end
                    end
                    ST_LINKED: begin
                        timer_reg <= '0;
                        if (!uplinkrdy_i || !mgt_rx_rdy_i || relock) begin
                            state_reg     <= ST_BACKOFF;
                            outs_reg      <= outs_for(ST_BACKOFF);
                            retry_cnt_reg <= sat_inc8(retry_cnt_reg);
                        end
                    end
                    ST_BACKOFF: begin
                        if (timer_reg == BO_LAST) begin
                            state_reg <= ST_MGT_RST;
                            outs_reg  <= outs_for(ST_MGT_RST);
                            timer_reg <= '0;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        outs_reg  <= outs_for(ST_IDLE);
                        timer_reg <= '0;
                    end
                endcase
            end
            if (cnt_clr_i) begin
                retry_cnt_reg <= '0;
            end
        end
    end

    // Total FEC-corrected frames seen while the link is up.
    always_ff @(posedge clk40_i) begin
        if (rst_i || cnt_clr_i) begin
            fec_cnt_reg <= '0;
        end else if ((state_reg == ST_LINKED) && uplinkFEC_i) begin
            fec_cnt_reg <= sat_inc16(fec_cnt_reg);
        end
    end

    assign mgt_rst_o    = outs_reg.mgt_rst;
    assign uplink_rst_o = outs_reg.uplink_rst;
    assign link_up_o    = outs_reg.link_up;
    assign state_o      = state_reg;
    assign retry_cnt_o  = retry_cnt_reg;
    assign fec_cnt_o    = fec_cnt_reg;

endmodule

// File: tb/tb_lpgbt_uplink_link_ctrl.sv
// Directed bench for lpgbt_uplink_link_ctrl: a default-parameter instance for
// the bring-up, timeout, FEC and enable scenarios and a small-parameter
// instance for the ready/timeout race and retry saturation.
module tb_lpgbt_uplink_link_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic rst = 1'b1, en = 1'b0, rx = 1'b0, upl = 1'b0, fec = 1'b0, clr = 1'b0;
    logic mgt_rst, upl_rst, link_up;
    logic [2:0]  st;
    logic [7:0]  retry;
    logic [15:0] fec_cnt;

    // small-parameter instance
    logic rst_f = 1'b1, en_f = 1'b0, rx_f = 1'b0, upl_f = 1'b0, fec_f = 1'b0, clr_f = 1'b0;
    logic mgt_rst_f, upl_rst_f, link_up_f;
    logic [2:0]  st_f;
    logic [7:0]  retry_f;
    logic [15:0] fec_cnt_f;

    lpgbt_uplink_link_ctrl dut (
        .clk40_i(clk), .rst_i(rst), .enable_i(en), .mgt_rx_rdy_i(rx),
        .uplinkrdy_i(upl), .uplinkFEC_i(fec), .cnt_clr_i(clr),
        .mgt_rst_o(mgt_rst), .uplink_rst_o(upl_rst), .link_up_o(link_up),
        .state_o(st), .retry_cnt_o(retry), .fec_cnt_o(fec_cnt)
    );

    lpgbt_uplink_link_ctrl #(
        .RST_CYCLES(2), .TIMEOUT_CYCLES(8), .BACKOFF_CYCLES(2),
        .FEC_WINDOW(16), .FEC_LIMIT(3)
    ) dut_fast (
        .clk40_i(clk), .rst_i(rst_f), .enable_i(en_f), .mgt_rx_rdy_i(rx_f),
        .uplinkrdy_i(upl_f), .uplinkFEC_i(fec_f), .cnt_clr_i(clr_f),
        .mgt_rst_o(mgt_rst_f), .uplink_rst_o(upl_rst_f), .link_up_o(link_up_f),
        .state_o(st_f), .retry_cnt_o(retry_f), .fec_cnt_o(fec_cnt_f)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("check %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input bit fast, input logic [2:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while (((fast ? st_f : st) != s) && (n < budget)) begin
            tick();
            n++;
        end
        check_val(tag, fast ? st_f : st, s);
    endtask

    task automatic fec_pulses(input int count);
        for (int i = 0; i < count; i++) begin
            fec = 1'b1;
            tick();
            fec = 1'b0;
            if (i < count - 1) repeat (9) tick();
        end
    endtask

    initial begin
        int mgt_cycles, uplrst_cycles, first_mgt, first_link, n;
        mgt_cycles = 0; uplrst_cycles = 0; first_mgt = -1; first_link = -1;

        // reset state
        repeat (3) tick();
        check_val("rst_state", st, 3'd0);
        check_val("rst_mgt_rst", mgt_rst, 1);
        check_val("rst_upl_rst", upl_rst, 1);
        check_val("rst_link_up", link_up, 0);
        check_val("rst_retry", retry, 0);
        check_val("rst_fec", fec_cnt, 0);
        rst = 1'b0;
        rst_f = 1'b0;
        tick();
        check_val("idle_hold", st, 3'd0);

        // bring-up: rx_rdy at clock 30, uplinkrdy at clock 60
        en = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (st == 3'd1) begin
                if (mgt_rst) mgt_cycles++;
                if (first_mgt < 0) first_mgt = c;
            end
            if (st == 3'd3) uplrst_cycles++;
            if (st == 3'd5 && first_link < 0) first_link = c;
            if (c == 17) begin
                check_val("wait_mgt_state", st, 3'd2);
                check_val("wait_mgt_mgt_rst", mgt_rst, 0);
                check_val("wait_mgt_upl_rst", upl_rst, 1);
            end
            if (c == 47) begin
                check_val("wait_lock_state", st, 3'd4);
                check_val("wait_lock_upl_rst", upl_rst, 0);
            end
            if (c == 30) rx = 1'b1;
            if (c == 60) upl = 1'b1;
        end
        check_val("first_mgt_cycle", first_mgt, 1);
        check_val("mgt_rst_len", mgt_cycles, 16);
        check_val("upl_rst_len", uplrst_cycles, 16);
        check_val("first_link_cycle", first_link, 61);
        check_val("linked_link_up", link_up, 1);
        check_val("linked_retry", retry, 0);

        // uplink lock drop while linked
        upl = 1'b0;
        tick();
        check_val("drop_state", st, 3'd6);
        check_val("drop_link_up", link_up, 0);
        check_val("drop_retry", retry, 1);
        check_val("backoff_mgt_rst", mgt_rst, 1);
        upl = 1'b1;
        wait_state(1'b0, 3'd5, 700, "relink1");

        // drop with simultaneous counter clear
        upl = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_val("clr_drop_state", st, 3'd6);
        check_val("clr_drop_retry", retry, 0);
        upl = 1'b1;
        wait_state(1'b0, 3'd5, 700, "relink2");

        // 8 FEC pulses inside one window force a relock
        fec_pulses(8);
        check_val("fec8_still_linked", st, 3'd5);
        check_val("fec8_cnt", fec_cnt, 8);
        tick();
        check_val("fec8_backoff", st, 3'd6);
        check_val("fec8_retry", retry, 1);
        check_val("fec8_cnt_kept", fec_cnt, 8);
        wait_state(1'b0, 3'd5, 700, "relink3");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_val("clr_fec", fec_cnt, 0);
        check_val("clr_retry", retry, 0);

        // 7 pulses in each of two windows keeps the link
        fec_pulses(7);
        repeat (1100) tick();
        fec_pulses(7);
        repeat (5) tick();
        check_val("fec7_state", st, 3'd5);
        check_val("fec7_cnt", fec_cnt, 14);

        // rx_rdy lost: backoff, then WAIT_MGT timeout, then backoff length
        rx = 1'b0;
        tick();
        check_val("rx_drop_state", st, 3'd6);
        check_val("rx_drop_retry", retry, 1);
        wait_state(1'b0, 3'd2, 400, "reach_wait_mgt");
        n = 1;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (st == 3'd2) n++;
            else break;
        end
        check_val("wait_mgt_len", n, 4096);
        check_val("timeout_state", st, 3'd6);
        check_val("timeout_retry", retry, 2);
        n = 1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (st == 3'd6) n++;
            else break;
        end
        check_val("backoff_len", n, 256);
        check_val("backoff_exit_state", st, 3'd1);

        // disable while in WAIT_LOCK keeps counters
        rx = 1'b1;
        upl = 1'b0;
        wait_state(1'b0, 3'd4, 100, "reach_wait_lock");
        en = 1'b0;
        tick();
        check_val("dis_state", st, 3'd0);
        check_val("dis_mgt_rst", mgt_rst, 1);
        check_val("dis_upl_rst", upl_rst, 1);
        check_val("dis_link_up", link_up, 0);
        check_val("dis_retry", retry, 2);
        check_val("dis_fec", fec_cnt, 14);
        repeat (3) tick();
        check_val("dis_hold", st, 3'd0);

        // reset mid-sequence aborts to IDLE and clears counters
        en = 1'b1;
        wait_state(1'b0, 3'd1, 10, "reach_mgt_rst");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_val("abort_state", st, 3'd0);
        check_val("abort_mgt_rst", mgt_rst, 1);
        check_val("abort_retry", retry, 0);
        check_val("abort_fec", fec_cnt, 0);
        rst = 1'b0;
        en = 1'b0;

        // ready arriving on the timeout clock wins
        en_f = 1'b1;
        wait_state(1'b1, 3'd2, 50, "fast_wait_mgt");
        repeat (7) tick();
        check_val("fast_wait_mgt_hold", st_f, 3'd2);
        rx_f = 1'b1;
        tick();
        check_val("race_ready_wins", st_f, 3'd3);
        rx_f = 1'b0;

        // more than 255 failures saturate the retry counter
        repeat (4000) tick();
        check_val("retry_saturate", retry_f, 255);
        check_val("fast_link_up", link_up_f, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
